// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache refill controller.
// Holds the refill FSM state encoding and the line-alignment helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } refill_state_e;

  localparam int unsigned DEFAULT_WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_BITS            = $clog2(DEFAULT_WORDS_PER_LINE) + 2;

  // Byte-offset bits inside one line for a given line size in words.
  function automatic int unsigned offset_bits_of(input int unsigned words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  // Mask that clears the in-line byte offset; callers slice it to their width.
  function automatic logic [63:0] line_base_mask(input int unsigned words_per_line);
    return ~((64'd1 << offset_bits_of(words_per_line)) - 64'd1);
  endfunction

endpackage

// File: rtl/refill_word_counter.sv
// Word index within the line being refilled: cleared on load, stepped on
// each accepted word, and flags the last word of the line.
module refill_word_counter #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Next index: load wins over increment, otherwise hold.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Index register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler for the fetch stage.
// On a miss it stalls fetch, reads the whole line one word at a time from
// instruction memory (one outstanding request), writes each word into the
// cache and releases the stall one cycle after the last word lands.
// Optional build macro: ICACHE_PERF_EN adds saturating hit/miss counters;
// without it miss_count and hit_count are tied to zero.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic                  hit,
  input  logic                  flushE,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_waddr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  stallF,
  output logic                  instr_validF,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  hit_count
);

  localparam int unsigned IDX_W   = $clog2(WORDS_PER_LINE);
  localparam logic [63:0] LB_MASK = line_base_mask(WORDS_PER_LINE);

  refill_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] line_base_q, line_base_d;
  logic                  drop_q, drop_d;

  logic                  idx_load;
  logic                  idx_inc;
  logic [IDX_W-1:0]      idx;
  logic                  idx_last;
  logic [DATA_WIDTH-1:0] word_addr;

  refill_word_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .IDX_W         (IDX_W)
  ) u_word_counter (
    .clk  (clk),
    .reset(reset),
    .load (idx_load),
    .inc  (idx_inc),
    .idx  (idx),
    .last (idx_last)
  );

  // line_base is aligned, so OR-ing the word offset can never carry out.
  assign word_addr = line_base_q | {{(DATA_WIDTH - IDX_W - 2){1'b0}}, idx, 2'b00};

  // Next-state logic for the refill FSM, line base and redirect-drop flag.
  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    drop_d      = drop_q;
    idx_load    = 1'b0;
    idx_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit && !flushE) begin
          state_d     = REQ;
          line_base_d = PCF & LB_MASK[DATA_WIDTH-1:0];
          drop_d      = 1'b0;
          idx_load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A redirect cannot cancel the memory transaction; just remember it.
        if (flushE) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (mem_gnt) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (flushE) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (mem_rvalid) begin
          if (idx_last) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            idx_inc = 1'b1;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        // The IDLE lookup re-evaluates whatever PCF now holds.
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Refill FSM state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      line_base_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      drop_q      <= drop_d;
    end
  end

  // Output decode; reset forces every output to its idle value at once so a
  // stray rvalid during reset never reaches the cache.
  always_comb begin
    mem_req      = 1'b0;
    mem_addr     = '0;
    cache_we     = 1'b0;
    cache_waddr  = '0;
    cache_wdata  = '0;
    stallF       = 1'b0;
    instr_validF = 1'b0;
    if (reset) begin
      mem_req = 1'b0;
    end else begin
      mem_req      = (state_q == REQ);
      cache_we     = (state_q == WAIT) && mem_rvalid;
      stallF       = (state_q != IDLE) || (!hit && !flushE);
      instr_validF = (state_q == IDLE) && hit;
      if (state_q == REQ) begin
        mem_addr = word_addr;
      end else begin
        mem_addr = '0;
      end
      if ((state_q == WAIT) && mem_rvalid) begin
        cache_waddr = word_addr;
        cache_wdata = mem_rdata;
      end else begin
        cache_waddr = '0;
        cache_wdata = '0;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  // Saturating counters: hit fetch cycles and refills entering DONE.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && hit && !flushE && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + CNT_WIDTH'(1);
    end else begin
      hit_count_d = hit_count_q;
    end
    if ((state_q == WAIT) && mem_rvalid && idx_last && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  // Performance counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2-3
// units later, well away from the next edge.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        hit;
  logic        flushE;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        cache_we;
  logic [31:0] cache_waddr;
  logic [31:0] cache_wdata;
  logic        stallF;
  logic        instr_validF;
  logic [31:0] miss_count;
  logic [31:0] hit_count;

  int checks   = 0;
  int failures = 0;
  int s;

  icache_refill_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .hit         (hit),
    .flushE      (flushE),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .cache_we    (cache_we),
    .cache_waddr (cache_waddr),
    .cache_wdata (cache_wdata),
    .stallF      (stallF),
    .instr_validF(instr_validF),
    .miss_count  (miss_count),
    .hit_count   (hit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full line refill starting from the IDLE miss cycle. Optionally holds
  // mem_gnt low for delay_cycles on word delay_word, and pulses flushE with
  // a new PCF during the WAIT of word flush_word. Returns stalled cycles
  // observed after the miss cycle.
  task automatic run_refill(input logic [31:0] pc, input int delay_word,
                            input int delay_cycles, input int flush_word,
                            input logic [31:0] new_pc, output int stalls);
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    base   = pc & 32'hFFFF_FFF0;
    stalls = 0;
    PCF = pc; hit = 1'b0; flushE = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #2;
    checks++;
    if (stallF !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL miss_cycle pc=%h: stallF=%b mem_req=%b, required stallF=1 mem_req=0", pc, stallF, mem_req);
    end
    tick();
    for (int w = 0; w < 4; w++) begin
      exp_addr = base + 32'(w * 4);
      exp_data = base ^ 32'hA5A5_0000 ^ 32'(w);
      if (w == delay_word) begin
        for (int d = 0; d < delay_cycles; d++) begin
          mem_gnt = 1'b0;
          #2;
          checks++;
          if (mem_req !== 1'b1 || mem_addr !== exp_addr || cache_we !== 1'b0 || stallF !== 1'b1) begin
            failures++;
            $display("FAIL gnt_hold w%0d d%0d: req=%b addr=%h we=%b stall=%b, required req=1 addr=%h we=0 stall=1",
                     w, d, mem_req, mem_addr, cache_we, stallF, exp_addr);
          end
          if (stallF === 1'b1) stalls++;
          tick();
        end
      end
      mem_gnt = 1'b1;
      #2;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr || stallF !== 1'b1 || cache_we !== 1'b0) begin
        failures++;
        $display("FAIL req w%0d: req=%b addr=%h stall=%b we=%b, required req=1 addr=%h stall=1 we=0",
                 w, mem_req, mem_addr, stallF, cache_we, exp_addr);
      end
      if (stallF === 1'b1) stalls++;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = exp_data;
      if (w == flush_word) begin
        flushE = 1'b1;
        PCF    = new_pc;
      end
      #2;
      checks++;
      if (cache_we !== 1'b1 || cache_waddr !== exp_addr || cache_wdata !== exp_data ||
          mem_req !== 1'b0 || stallF !== 1'b1) begin
        failures++;
        $display("FAIL write w%0d: we=%b waddr=%h wdata=%h req=%b stall=%b, required we=1 waddr=%h wdata=%h req=0 stall=1",
                 w, cache_we, cache_waddr, cache_wdata, mem_req, stallF, exp_addr, exp_data);
      end
      if (stallF === 1'b1) stalls++;
      tick();
      mem_rvalid = 1'b0; flushE = 1'b0;
    end
    #2;
    checks++;
    if (stallF !== 1'b1 || cache_we !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle: stall=%b we=%b req=%b, required stall=1 we=0 req=0", stallF, cache_we, mem_req);
    end
    if (stallF === 1'b1) stalls++;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; hit = 1'b0; flushE = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; PCF = 32'h10;
    tick(); tick();
    #2;
    checks++;
    if ({mem_req, mem_addr, cache_we, cache_waddr, cache_wdata, stallF, instr_validF, miss_count, hit_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b addr=%h we=%b waddr=%h wdata=%h stall=%b iv=%b miss=%0d hits=%0d, required all 0",
               mem_req, mem_addr, cache_we, cache_waddr, cache_wdata, stallF, instr_validF, miss_count, hit_count);
    end
    reset = 1'b0; hit = 1'b1;
    #1;
    checks++;
    if (instr_validF !== 1'b1 || stallF !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_hit: iv=%b stall=%b, required iv=1 stall=0", instr_validF, stallF);
    end
    tick();
  endtask

  task automatic test_cold_miss();
    run_refill(32'h0000_0010, -1, 0, -1, 32'h0, s);
    checks++;
    if (s !== 9) begin
      failures++;
      $display("FAIL cold_stall_cycles: got %0d, required 9", s);
    end
    hit = 1'b1;
    #2;
    checks++;
    if (instr_validF !== 1'b1 || stallF !== 1'b0) begin
      failures++;
      $display("FAIL cold_release: iv=%b stall=%b, required iv=1 stall=0", instr_validF, stallF);
    end
    tick();
  endtask

  task automatic test_gnt_stall();
    run_refill(32'h0000_0010, 1, 3, -1, 32'h0, s);
    checks++;
    if (s !== 12) begin
      failures++;
      $display("FAIL gnt_stall_cycles: got %0d, required 12", s);
    end
  endtask

  task automatic test_flush_in_wait();
    run_refill(32'h0000_0024, -1, 0, 1, 32'h0000_0100, s);
    run_refill(32'h0000_0100, -1, 0, -1, 32'h0, s);
    checks++;
    if (s !== 9) begin
      failures++;
      $display("FAIL flush_second_refill_cycles: got %0d, required 9", s);
    end
  endtask

  task automatic test_miss_with_flush();
    PCF = 32'h0000_0200; hit = 1'b0; flushE = 1'b1;
    #2;
    checks++;
    if (stallF !== 1'b0 || mem_req !== 1'b0 || instr_validF !== 1'b0) begin
      failures++;
      $display("FAIL flush_miss_same: stall=%b req=%b iv=%b, required 0 0 0", stallF, mem_req, instr_validF);
    end
    tick();
    #2;
    checks++;
    if (stallF !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_miss_next: stall=%b req=%b, required 0 0", stallF, mem_req);
    end
    flushE = 1'b0; hit = 1'b1;
    #1;
    checks++;
    if (instr_validF !== 1'b1) begin
      failures++;
      $display("FAIL flush_miss_idle: iv=%b, required 1", instr_validF);
    end
    tick();
  endtask

  task automatic test_addr_wrap();
    run_refill(32'hFFFF_FFF4, -1, 0, -1, 32'h0, s);
  endtask

  task automatic test_back_to_back();
    run_refill(32'h0000_0040, -1, 0, -1, 32'h0, s);
    run_refill(32'h0000_0044, -1, 0, -1, 32'h0, s);
  endtask

  task automatic test_reset_mid_refill();
    PCF = 32'h0000_0080; hit = 1'b0; flushE = 1'b0;
    tick();
    for (int w = 0; w < 2; w++) begin
      mem_gnt = 1'b1; tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_0000 + 32'(w); tick();
      mem_rvalid = 1'b0;
    end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0;
    #2;
    checks++;
    if (stallF !== 1'b1 || mem_req !== 1'b0 || cache_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_w2: stall=%b req=%b we=%b, required 1 0 0", stallF, mem_req, cache_we);
    end
    reset = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    checks++;
    if ({mem_req, mem_addr, cache_we, cache_waddr, cache_wdata, stallF, instr_validF} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: req=%b addr=%h we=%b waddr=%h wdata=%h stall=%b iv=%b, required all 0",
               mem_req, mem_addr, cache_we, cache_waddr, cache_wdata, stallF, instr_validF);
    end
    reset = 1'b0; hit = 1'b1;
    #1;
    checks++;
    if (cache_we !== 1'b0 || mem_req !== 1'b0 || stallF !== 1'b0 || instr_validF !== 1'b1) begin
      failures++;
      $display("FAIL stray_rvalid_after_reset: we=%b req=%b stall=%b iv=%b, required 0 0 0 1",
               cache_we, mem_req, stallF, instr_validF);
    end
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_perf();
    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
`ifdef ICACHE_PERF_EN
    exp_hits = 32'd5;
    exp_miss = 32'd2;
`else
    exp_hits = 32'd0;
    exp_miss = 32'd0;
`endif
    reset = 1'b1; hit = 1'b0; flushE = 1'b0;
    tick();
    reset = 1'b0; hit = 1'b1;
    repeat (5) tick();
    run_refill(32'h0000_0300, -1, 0, -1, 32'h0, s);
    run_refill(32'h0000_0310, -1, 0, -1, 32'h0, s);
    hit = 1'b0; flushE = 1'b1;
    #2;
    checks++;
    if (hit_count !== exp_hits || miss_count !== exp_miss) begin
      failures++;
      $display("FAIL perf_counts: hit_count=%0d miss_count=%0d, required %0d %0d",
               hit_count, miss_count, exp_hits, exp_miss);
    end
    tick();
    flushE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_gnt_stall();
    test_flush_in_wait();
    test_miss_with_flush();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid_refill();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-handling controller for the fetch-stage instruction cache.
- On a lookup miss at PCF it stalls fetch and issues one instruction-memory read per word of the line, in order. It then writes each returned word into the cache and releases the stall once the whole line is resident.
- Sits between the PC/cache lookup in fetch and the instruction-memory port. It drives the cache write port and the PC enable.

Parameters:
- DATA_WIDTH, 32, width of address and instruction words
- WORDS_PER_LINE, 4, words per cache line; power of two, >= 2
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- PCF  in  DATA_WIDTH  current fetch address (word aligned)
- hit  in  1  cache lookup hit for PCF, combinational from the cache
- flushE  in  1  redirect from execute (PCSrcE | JALRinstrE); current fetch is discarded
- mem_req  out  1  memory read request
- mem_addr  out  DATA_WIDTH  word address of the request
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- cache_we  out  1  cache write enable
- cache_waddr  out  DATA_WIDTH  address of the word written
- cache_wdata  out  DATA_WIDTH  data written
- stallF  out  1  freeze PC (PC enable = ~stallF)
- instr_validF  out  1  instrF from the cache is valid this cycle
- miss_count  out  CNT_WIDTH  completed refills (ICACHE_PERF_EN only)
- hit_count  out  CNT_WIDTH  hit fetch cycles (ICACHE_PERF_EN only)

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_req=0, mem_addr=0, cache_we=0, cache_waddr=0, cache_wdata=0.
  - stallF=0, instr_validF=0, counters=0.
- Reset mid-refill: the refill is abandoned immediately and a pending mem_rvalid is ignored. Partially written lines are left in the cache; cache valid bits are the cache's concern.
- line_base = PCF with the low log2(WORDS_PER_LINE)+2 bits cleared, latched on entry to REQ.
- A word index idx counts 0..WORDS_PER_LINE-1.
- States:
  - IDLE:
    - hit=1: instr_validF=1, stallF=0.
    - hit=0 and flushE=0: stallF=1 combinationally in the same cycle. Latch line_base, idx=0, go to REQ.
    - hit=0 and flushE=1: no refill starts; stay in IDLE with stallF=0.
  - REQ:
    - mem_req=1, mem_addr=line_base+4*idx.
    - mem_req and mem_addr are held stable until mem_gnt.
    - On mem_gnt go to WAIT.
  - WAIT:
    - mem_req=0; wait for mem_rvalid.
    - On mem_rvalid: cache_we=1, cache_waddr=line_base+4*idx, cache_wdata=mem_rdata in the same cycle.
    - If idx=WORDS_PER_LINE-1 go to DONE; else idx+1 and go to REQ.
    - mem_rvalid in any state other than WAIT is ignored.
  - DONE:
    - One cycle with stallF=1, letting the cache lookup on PCF resolve to hit.
    - Then go to IDLE; the next cycle re-looks up PCF.
- stallF=1 in REQ, WAIT and DONE. instr_validF=0 in every state except IDLE with hit=1.
- Memory ordering: one outstanding request at a time. Minimum latency is gnt in the request cycle and rvalid the next cycle. Refill then takes 2*WORDS_PER_LINE+1 stalled cycles after the miss cycle.
- flushE during REQ/WAIT:
  - The line refill always completes, since the memory transaction cannot be cancelled.
  - A sticky drop flag is set. PCF may change (the PC loads the redirect target regardless of stall).
  - In DONE the flag clears. The IDLE lookup uses the new PCF, so hit or miss is re-evaluated.
- flushE in DONE: no effect beyond the normal return to IDLE.
- Address wrap: line_base+4*idx never carries out of the line because line_base is aligned. Addresses near 0xFFFFFFF0 are handled with no overflow.
- A miss to the same line immediately after DONE is legal and starts a new refill.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - hit_count increments each IDLE cycle with hit=1 and flushE=0.
  - miss_count increments on each DONE entry.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: counter registers are not built and miss_count/hit_count are tied to 0.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, REQ, WAIT, DONE).
  - OFFSET_BITS = log2(WORDS_PER_LINE)+2.
  - line_base mask function.
- Natural sub-module: refill_word_counter (idx register with load/increment/last flag).
- Counters stay inline.

Test Plan:
- Cold miss at PCF=0x00000010, memory gnt same cycle, rvalid next cycle:
  - mem_addr sequence 0x10, 0x14, 0x18, 0x1C.
  - 4 cache writes with matching data.
  - stallF high exactly 9 cycles after the miss cycle; then instr_validF=1 with hit.
- Memory holds mem_gnt low for 3 cycles on the second word: mem_req and mem_addr=0x14 stay stable all 3 cycles, with no cache_we.
- Miss at 0x00000024, flushE pulsed during WAIT of word 1, PCF changes to 0x00000100 (miss):
  - Line 0x20 still fully written.
  - DONE, then a new refill at 0x100..0x10C.
- Miss with flushE in the same cycle: no mem_req issued, stallF=0, state stays IDLE.
- Reset asserted in WAIT of word 2:
  - Next cycle all outputs are at reset values.
  - A stray mem_rvalid produces no cache_we.
- ICACHE_PERF_EN: 5 hit cycles plus 2 completed refills give hit_count=5, miss_count=2. Without the macro both read 0.
